// File: rtl/flp_shift_if.sv
// Operand/result bundle for the constant-distance shift unit.
// The master drives the operands and the slave returns the registered results.
interface flp_shift_if #(
  parameter int INWIDTH  = 32,
  parameter int OUTWIDTH = 32
);
  logic                in_valid;
  logic [INWIDTH-1:0]  shl_i;
  logic [INWIDTH-1:0]  shr_i;
  logic                out_valid;
  logic [OUTWIDTH-1:0] shl_o;
  logic [OUTWIDTH-1:0] shr_o;

  modport master (
    output in_valid, shl_i, shr_i,
    input  out_valid, shl_o, shr_o
  );

  modport slave (
    input  in_valid, shl_i, shr_i,
    output out_valid, shl_o, shr_o
  );
endinterface

// File: rtl/flp_shift_unit.sv
// Two-lane constant shift: left pad-shift and right jam-shift, one cycle of latency, no backpressure.
// FLP_SHIFTS_JAM_EN: when defined, shifted-out right-lane bits are ORed into shr_o[0].
module flp_shift_unit #(
  parameter int INWIDTH  = 32,
  parameter int OUTWIDTH = 32,
  parameter int SHAMT    = 8
) (
  input  logic         clk,
  input  logic         rst,
  flp_shift_if.slave   io
);
  localparam int WMAX = (INWIDTH > OUTWIDTH) ? INWIDTH : OUTWIDTH;
  localparam int WL   = WMAX + SHAMT;

  logic [OUTWIDTH-1:0] shl_d;
  logic [OUTWIDTH-1:0] shr_d;
`ifdef FLP_SHIFTS_JAM_EN
  logic                sticky;
`endif

  always_comb begin
    // Widen before shifting so nothing is lost until the final truncation.
    shl_d = OUTWIDTH'(WL'(io.shl_i) << SHAMT);
    shr_d = OUTWIDTH'(WMAX'(io.shr_i) >> SHAMT);
`ifdef FLP_SHIFTS_JAM_EN
    // Mask covers the low SHAMT bits; it saturates to all ones when SHAMT >= WMAX.
    sticky   = |(WMAX'(io.shr_i) & ~({WMAX{1'b1}} << SHAMT));
    shr_d[0] = shr_d[0] | sticky;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io.out_valid <= 1'b0;
      io.shl_o     <= '0;
      io.shr_o     <= '0;
    end else begin
      io.out_valid <= io.in_valid;
      if (io.in_valid) begin
        io.shl_o <= shl_d;
        io.shr_o <= shr_d;
      end
    end
  end
endmodule

// File: tb/tb_flp_shift_unit.sv
// Scoreboard bench for flp_shift_unit at 32/32/8: directed cases, reset cases, then random traffic.
module tb_flp_shift_unit;
  typedef struct {
    logic [31:0] shl;
    logic [31:0] shr;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  exp_t q[$];
  logic [31:0] last_shl = '0;
  logic [31:0] last_shr = '0;

  flp_shift_if #(.INWIDTH(32), .OUTWIDTH(32)) bus ();

  flp_shift_unit #(.INWIDTH(32), .OUTWIDTH(32), .SHAMT(8)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at cycle %0d", name, act, req, cyc);
  endtask

  // Reference: shift by 8 with 64-bit arithmetic, sticky is any nonzero low byte.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int stamp);
    exp_t e;
    longint unsigned wide;
    wide  = longint'(a) * 256;
    e.shl = wide[31:0];
    e.shr = b / 256;
`ifdef FLP_SHIFTS_JAM_EN
    if ((b % 256) != 0) e.shr = e.shr | 32'd1;
`endif
    e.cyc = stamp;
    return e;
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.shl_i    = a;
    bus.shr_i    = b;
    q.push_back(model(a, b, cyc + 1));
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.shl_i    = $urandom;
    bus.shr_i    = $urandom;
    @(posedge clk); #1;
  endtask

  // Monitor: compares at the falling edge, away from capture.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_shl_o", bus.shl_o, 32'd0);
      check("rst_shr_o", bus.shr_o, 32'd0);
    end else if (bus.out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("latency_cycle", cyc, e.cyc);
        check("shl_o", bus.shl_o, e.shl);
        check("shr_o", bus.shr_o, e.shr);
        last_shl = e.shl;
        last_shr = e.shr;
      end
    end else begin
      check("hold_shl_o", bus.shl_o, last_shl);
      check("hold_shr_o", bus.shr_o, last_shr);
    end
  end

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.shl_i    = '0;
    bus.shr_i    = '0;
    #3;
    check("por_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("por_shl_o", bus.shl_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    send(32'h0000_0000, 32'h0000_0000);
    send(32'h0000_0001, 32'h0000_0001);
    send(32'h0000_1000, 32'h0000_1000);
    send(32'h1000_0000, 32'h1000_0000);
    send(32'h1000_0000, 32'h1000_0001);
    send(32'hFFFF_FFFF, 32'hFFFF_FF00);
    send(32'h00AB_CDEF, 32'h8000_0080);
    repeat (3) idle();
    send(32'h0123_4567, 32'h89AB_CDEF);
    send(32'h00FF_FFFF, 32'h0000_00FF);

    // Mid-stream reset, asserted between edges: the just-captured result is discarded.
    send(32'h0000_0F0F, 32'hF0F0_0001);
    rst = 1'b1;
    void'(q.pop_back());
    #1;
    check("async_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("async_rst_shl_o", bus.shl_o, 32'd0);
    check("async_rst_shr_o", bus.shr_o, 32'd0);
    bus.in_valid = 1'b1;
    bus.shl_i    = 32'hDEAD_BEEF;
    bus.shr_i    = 32'hCAFE_F00D;
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst          = 1'b0;
    last_shl     = '0;
    last_shr     = '0;
    idle();
    send(32'h0000_0000, 32'h0000_0000);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = $urandom;
      if ($urandom_range(3) == 0) b[7:0] = 8'h00;
      if ($urandom_range(3) != 0) send(a, b);
      else idle();
    end
    bus.in_valid = 1'b0;

    for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_queue_empty", q.size(), 32'd0);
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
